csr_file: RTL and testbench
===========================

CSR_FILE -- requirements
Module: csr_file

Interface
REQ-001 Parameter XLEN, default 32, data width of every CSR and data port (32 or 64).
REQ-002 Parameter MSTATUS_RST, default 32'h88, mstatus reset value.
REQ-003 Parameter MTVEC_RST, default 32'h0, mtvec reset value.
REQ-004 Parameter HART_ID, default 0, value returned by mhartid.
REQ-005 Ports: clk in 1, rising-edge clock; rst in 1, reset. One clock; reset is synchronous and active-low.
REQ-006 Ports: raddr in 12, read address; rdata out XLEN, read data (combinational); rvalid out 1, raddr implemented.
REQ-007 Ports: waddr in 12, write address; wdata in XLEN, write operand; csr_w in 1, write enable; csr_wsc_mode in 2, 01 write / 10 set / 11 clear / 00 write.
REQ-008 Ports: w_illegal out 1, combinational, csr_w with unimplemented or read-only waddr.
REQ-009 Ports: instret_inc in 1, retire pulse; trap_valid in 1; trap_pc in XLEN; trap_cause in XLEN; trap_tval in XLEN; mret in 1.
REQ-010 Ports: mstatus, mepc, mtvec out XLEN, register copies; trap_target out XLEN, handler address; mret_target out XLEN, equals mepc.

Function
REQ-011 Implemented map: mstatus 300, misa 301 (RO), mie 304, mtvec 305, mscratch 340, mepc 341, mcause 342, mtval 343, mip 344, mcycle B00, minstret B02, mcycleh B80, minstreth B82 (XLEN=32 only), mhartid F14 (RO). All other addresses are unimplemented.
REQ-012 rdata: value of raddr register before the current edge; 0 with rvalid=0 when unimplemented.
REQ-013 Write on csr_w and not w_illegal: new = wdata, old|wdata, or old&~wdata per mode; committed at the next edge.
REQ-014 Illegal write: no state change; w_illegal asserted the same cycle.
REQ-015 mepc bits [1:0] are always stored as 0; mtvec bit 1 is always stored as 0.
REQ-016 mcycle: 64-bit counter, +1 every cycle, wraps from all-ones to 0.
REQ-017 minstret: 64-bit counter, +1 on each instret_inc cycle, wraps from all-ones to 0.
REQ-018 XLEN=32: mcycle/minstret access bits [31:0]; the h addresses access bits [63:32]. A carry from the low half propagates the same cycle.
REQ-019 A CSR write to a counter half in the same cycle as an increment: the written value wins for that half and no increment is applied to the whole counter that cycle.
REQ-020 trap_valid at an edge: mepc<=trap_pc, mcause<=trap_cause, mtval<=trap_tval, MPIE(bit7)<=MIE(bit3), MIE<=0, MPP(bits12:11)<=2'b11.
REQ-021 mret at an edge: MIE<=MPIE, MPIE<=1, MPP<=2'b11.
REQ-022 Priority: trap_valid over mret over CSR write. A lower-priority CSR write to a register touched by the higher-priority event is dropped; writes to other CSRs still commit.
REQ-023 trap_target: mtvec base (mtvec with bits [1:0]=0), plus 4*cause[XLEN-2:0] when mtvec[0]=1 and trap_cause MSB=1; combinational from current mtvec and trap_cause.
REQ-024 mip is read-only zero in this revision; writes to mip are legal and ignored.

Reset
REQ-025 On rst=0 at an edge: mstatus=MSTATUS_RST, mtvec=MTVEC_RST; all other writable CSRs and both counters = 0.
REQ-026 misa reads the constant RV32I/RV64I value with the M-extension bit clear.
REQ-027 Reset has priority over trap, mret, write and increment in the same cycle.

Structure
REQ-028 A shared package holds the CSR address constants, write-mode encodings and mstatus bit positions.
REQ-029 One sub-module csr_counter64 (inc, write-low, write-high, value) instantiated for mcycle and minstret.

Verification
REQ-030 Reset release, then read 300 -> 0x88; read 305 -> MTVEC_RST; read F14 -> HART_ID; read 7C0 -> rdata 0 and rvalid 0.
REQ-031 Write 340=0xA5A5_0000, set 0x00FF, then clear 0xA500_0000 -> reads 0x00A5_00FF; a write to F14 asserts w_illegal and leaves the value unchanged.
REQ-032 Write mcycle=0xFFFF_FFFE and mcycleh=0 -> two cycles later mcycleh=1 and mcycle=0.
REQ-033 mstatus=0x8, trap_valid with pc 0x104, cause 0x8000_0007, mtvec 0x101 -> mepc 0x104, MIE 0, MPIE 1, trap_target 0x11C; then mret -> MIE 1.
REQ-034 Same-cycle trap_valid and csr_w to 341 -> mepc equals trap_pc; same-cycle csr_w to 340 commits.
REQ-035 rst low in the middle of a counter run with instret_inc high -> both counters 0 on the next cycle.

Source files
------------

// File: rtl/csr_file_pkg.sv
// csr_file_pkg: shared definitions for the machine-mode CSR file.
//   - CSR address map constants
//   - csr_wsc_mode encodings (write / set / clear)
//   - mstatus bit positions touched by trap entry and mret
//   - a packed view of every readable CSR plus a lookup helper so the
//     read port and the read-modify-write path share one address decoder
package csr_file_pkg;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MISA      = 12'h301;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MTVAL     = 12'h343;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    typedef enum logic [1:0] {
        WSC_WRITE_ALT = 2'b00,
        WSC_WRITE     = 2'b01,
        WSC_SET       = 2'b10,
        WSC_CLEAR     = 2'b11
    } wsc_mode_e;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    // All CSRs widened to 64 bits so the helpers work for either XLEN.
    typedef struct packed {
        logic [63:0] mstatus;
        logic [63:0] misa;
        logic [63:0] mie;
        logic [63:0] mtvec;
        logic [63:0] mscratch;
        logic [63:0] mepc;
        logic [63:0] mcause;
        logic [63:0] mtval;
        logic [63:0] mcycle;
        logic [63:0] minstret;
        logic [63:0] mhartid;
    } csr_view_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] data;
    } csr_read_t;

    // Address decode: the h halves of the counters exist only when xlen32,
    // and with xlen32 the base counter addresses expose only the low half.
    function automatic csr_read_t csr_lookup(input csr_view_t v,
                                             input logic [11:0] addr,
                                             input logic xlen32);
        csr_read_t r;
        r.valid = 1'b1;
        r.data  = '0;
        case (addr)
            CSR_MSTATUS:   r.data = v.mstatus;
            CSR_MISA:      r.data = v.misa;
            CSR_MIE:       r.data = v.mie;
            CSR_MTVEC:     r.data = v.mtvec;
            CSR_MSCRATCH:  r.data = v.mscratch;
            CSR_MEPC:      r.data = v.mepc;
            CSR_MCAUSE:    r.data = v.mcause;
            CSR_MTVAL:     r.data = v.mtval;
            CSR_MIP:       r.data = '0;
            CSR_MCYCLE:    r.data = xlen32 ? {32'h0, v.mcycle[31:0]} : v.mcycle;
            CSR_MINSTRET:  r.data = xlen32 ? {32'h0, v.minstret[31:0]} : v.minstret;
            CSR_MCYCLEH:   begin
                r.valid = xlen32;
                r.data  = xlen32 ? {32'h0, v.mcycle[63:32]} : 64'h0;
            end
            CSR_MINSTRETH: begin
                r.valid = xlen32;
                r.data  = xlen32 ? {32'h0, v.minstret[63:32]} : 64'h0;
            end
            CSR_MHARTID:   r.data = v.mhartid;
            default:       r.valid = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic [63:0] apply_wsc(input logic [63:0] old_val,
                                              input logic [63:0] operand,
                                              input logic [1:0]  mode);
        logic [63:0] res;
        case (mode)
            WSC_SET:   res = old_val | operand;
            WSC_CLEAR: res = old_val & ~operand;
            default:   res = operand;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/csr_file_counter64.sv
// csr_counter64: 64-bit free-running counter with independently writable
// 32-bit halves.
//   clk, rst (sync, active-low)
//   inc              increment request for this cycle
//   wr_lo / wr_hi    load wdata_lo / wdata_hi into the matching half
//   value            current 64-bit count
module csr_counter64 (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [31:0] wdata_lo,
    input  logic [31:0] wdata_hi,
    output logic [63:0] value
);

    // A write to either half suppresses the increment of the whole counter
    // that cycle, so software sees exactly the value it wrote.
    always_ff @(posedge clk) begin
        if (!rst) begin
            value <= '0;
        end else if (wr_lo || wr_hi) begin
            if (wr_lo) value[31:0]  <= wdata_lo;
            if (wr_hi) value[63:32] <= wdata_hi;
        end else if (inc) begin
            value <= value + 64'd1;
        end
    end

endmodule

// File: rtl/csr_file.sv
// csr_file: machine-mode CSR file with trap entry / mret handling.
//   clk, rst (sync, active-low)
//   raddr -> rdata, rvalid         combinational read port
//   waddr, wdata, csr_w, csr_wsc_mode -> write / set / clear, w_illegal
//   instret_inc                    retire pulse for minstret
//   trap_valid, trap_pc, trap_cause, trap_tval, mret
//   mstatus, mepc, mtvec           live register copies
//   trap_target, mret_target       handler / return addresses
module csr_file
    import csr_file_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] MSTATUS_RST = XLEN'(32'h88),
    parameter logic [XLEN-1:0] MTVEC_RST   = '0,
    parameter int              HART_ID     = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [11:0]     raddr,
    output logic [XLEN-1:0] rdata,
    output logic            rvalid,
    input  logic [11:0]     waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic            csr_w,
    input  logic [1:0]      csr_wsc_mode,
    output logic            w_illegal,
    input  logic            instret_inc,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_pc,
    input  logic [XLEN-1:0] trap_cause,
    input  logic [XLEN-1:0] trap_tval,
    input  logic            mret,
    output logic [XLEN-1:0] mstatus,
    output logic [XLEN-1:0] mepc,
    output logic [XLEN-1:0] mtvec,
    output logic [XLEN-1:0] trap_target,
    output logic [XLEN-1:0] mret_target
);

    localparam bit IS32 = (XLEN == 32);
    localparam logic [63:0] MISA_VAL = IS32 ? 64'h0000_0000_4000_0100
                                            : 64'h8000_0000_0000_0100;
    localparam logic [XLEN-1:0] MTVEC_MASK = {{(XLEN-2){1'b1}}, 2'b01};
    localparam logic [XLEN-1:0] MEPC_MASK  = {{(XLEN-2){1'b1}}, 2'b00};

    logic [XLEN-1:0] mie_q, mscratch_q, mcause_q, mtval_q;
    logic [63:0]     mcycle_q, minstret_q;
    csr_view_t       view;
    csr_read_t       rd, old;
    logic [63:0]     wr_val;
    logic            do_write;
    logic            cyc_wr_lo, cyc_wr_hi, ins_wr_lo, ins_wr_hi;
    logic [31:0]     cnt_wdata_hi;
    logic            unused_bits;

    always_comb begin
        view          = '0;
        view.mstatus  = 64'(mstatus);
        view.misa     = MISA_VAL;
        view.mie      = 64'(mie_q);
        view.mtvec    = 64'(mtvec);
        view.mscratch = 64'(mscratch_q);
        view.mepc     = 64'(mepc);
        view.mcause   = 64'(mcause_q);
        view.mtval    = 64'(mtval_q);
        view.mcycle   = mcycle_q;
        view.minstret = minstret_q;
        view.mhartid  = 64'(HART_ID);
    end

    assign rd     = csr_lookup(view, raddr, IS32);
    assign rdata  = rd.data[XLEN-1:0];
    assign rvalid = rd.valid;

    // The write port reuses the decoder to fetch the old value for set/clear.
    assign old       = csr_lookup(view, waddr, IS32);
    assign w_illegal = csr_w && (!old.valid || waddr == CSR_MISA || waddr == CSR_MHARTID);
    assign do_write  = csr_w && !w_illegal;
    assign wr_val    = apply_wsc(old.data, 64'(wdata), csr_wsc_mode);

    // With XLEN=64 the base counter address covers both halves at once.
    assign cyc_wr_lo    = do_write && (waddr == CSR_MCYCLE);
    assign cyc_wr_hi    = do_write && (waddr == (IS32 ? CSR_MCYCLEH : CSR_MCYCLE));
    assign ins_wr_lo    = do_write && (waddr == CSR_MINSTRET);
    assign ins_wr_hi    = do_write && (waddr == (IS32 ? CSR_MINSTRETH : CSR_MINSTRET));
    assign cnt_wdata_hi = IS32 ? wr_val[31:0] : wr_val[63:32];

    csr_counter64 u_mcycle (
        .clk      (clk),
        .rst      (rst),
        .inc      (1'b1),
        .wr_lo    (cyc_wr_lo),
        .wr_hi    (cyc_wr_hi),
        .wdata_lo (wr_val[31:0]),
        .wdata_hi (cnt_wdata_hi),
        .value    (mcycle_q)
    );

    csr_counter64 u_minstret (
        .clk      (clk),
        .rst      (rst),
        .inc      (instret_inc),
        .wr_lo    (ins_wr_lo),
        .wr_hi    (ins_wr_hi),
        .wdata_lo (wr_val[31:0]),
        .wdata_hi (cnt_wdata_hi),
        .value    (minstret_q)
    );

    // Software writes are gated off for any register that a trap or mret
    // updates in the same cycle; writes to unrelated CSRs still land.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mstatus    <= MSTATUS_RST;
            mtvec      <= MTVEC_RST & MTVEC_MASK;
            mie_q      <= '0;
            mscratch_q <= '0;
            mepc       <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
        end else begin
            if (do_write) begin
                case (waddr)
                    CSR_MSTATUS:  if (!trap_valid && !mret) mstatus <= wr_val[XLEN-1:0];
                    CSR_MIE:      mie_q      <= wr_val[XLEN-1:0];
                    CSR_MTVEC:    mtvec      <= wr_val[XLEN-1:0] & MTVEC_MASK;
                    CSR_MSCRATCH: mscratch_q <= wr_val[XLEN-1:0];
                    CSR_MEPC:     if (!trap_valid) mepc     <= wr_val[XLEN-1:0] & MEPC_MASK;
                    CSR_MCAUSE:   if (!trap_valid) mcause_q <= wr_val[XLEN-1:0];
                    CSR_MTVAL:    if (!trap_valid) mtval_q  <= wr_val[XLEN-1:0];
                    default:      ;
                endcase
            end
            if (trap_valid) begin
                mepc                                  <= trap_pc & MEPC_MASK;
                mcause_q                              <= trap_cause;
                mtval_q                               <= trap_tval;
                mstatus[MSTATUS_MPIE]                 <= mstatus[MSTATUS_MIE];
                mstatus[MSTATUS_MIE]                  <= 1'b0;
                mstatus[MSTATUS_MPP_HI:MSTATUS_MPP_LO] <= 2'b11;
            end else if (mret) begin
                mstatus[MSTATUS_MIE]                  <= mstatus[MSTATUS_MPIE];
                mstatus[MSTATUS_MPIE]                 <= 1'b1;
                mstatus[MSTATUS_MPP_HI:MSTATUS_MPP_LO] <= 2'b11;
            end
        end
    end

    // Vectored mode only applies to interrupts (cause MSB set).
    always_comb begin
        trap_target = {mtvec[XLEN-1:2], 2'b00};
        if (mtvec[0] && trap_cause[XLEN-1]) begin
            trap_target = {mtvec[XLEN-1:2], 2'b00} + {trap_cause[XLEN-3:0], 2'b00};
        end
    end

    assign mret_target = mepc;

    assign unused_bits = ^{rd.data, old.data, wr_val, trap_cause, trap_pc};

endmodule

// File: tb/tb_csr_file.sv
// tb_csr_file: directed plus randomized checks of csr_file (XLEN=32)
// against a behavioural model of the CSR map, trap/mret rules and counters.
module tb_csr_file;

    logic        clk;
    logic        rst;
    logic [11:0] raddr;
    logic [31:0] rdata;
    logic        rvalid;
    logic [11:0] waddr;
    logic [31:0] wdata;
    logic        csr_w;
    logic [1:0]  csr_wsc_mode;
    logic        w_illegal;
    logic        instret_inc;
    logic        trap_valid;
    logic [31:0] trap_pc;
    logic [31:0] trap_cause;
    logic [31:0] trap_tval;
    logic        mret;
    logic [31:0] mstatus;
    logic [31:0] mepc;
    logic [31:0] mtvec;
    logic [31:0] trap_target;
    logic [31:0] mret_target;

    int checks = 0;
    int errors = 0;

    // Reference state
    logic [31:0] m_mstatus, m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;
    logic [63:0] m_cycle, m_instret;

    csr_file dut (
        .clk          (clk),
        .rst          (rst),
        .raddr        (raddr),
        .rdata        (rdata),
        .rvalid       (rvalid),
        .waddr        (waddr),
        .wdata        (wdata),
        .csr_w        (csr_w),
        .csr_wsc_mode (csr_wsc_mode),
        .w_illegal    (w_illegal),
        .instret_inc  (instret_inc),
        .trap_valid   (trap_valid),
        .trap_pc      (trap_pc),
        .trap_cause   (trap_cause),
        .trap_tval    (trap_tval),
        .mret         (mret),
        .mstatus      (mstatus),
        .mepc         (mepc),
        .mtvec        (mtvec),
        .trap_target  (trap_target),
        .mret_target  (mret_target)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    // Returns {implemented, value} for the current model state.
    function automatic logic [32:0] modelRead(input logic [11:0] a);
        case (a)
            12'h300: return {1'b1, m_mstatus};
            12'h301: return {1'b1, 32'h4000_0100};
            12'h304: return {1'b1, m_mie};
            12'h305: return {1'b1, m_mtvec};
            12'h340: return {1'b1, m_mscratch};
            12'h341: return {1'b1, m_mepc};
            12'h342: return {1'b1, m_mcause};
            12'h343: return {1'b1, m_mtval};
            12'h344: return {1'b1, 32'h0};
            12'hB00: return {1'b1, m_cycle[31:0]};
            12'hB02: return {1'b1, m_instret[31:0]};
            12'hB80: return {1'b1, m_cycle[63:32]};
            12'hB82: return {1'b1, m_instret[63:32]};
            12'hF14: return {1'b1, 32'h0};
            default: return {1'b0, 32'h0};
        endcase
    endfunction

    function automatic logic modelIllegal(input logic [11:0] a, input logic w);
        logic [32:0] r;
        r = modelRead(a);
        return w && (!r[32] || a == 12'h301 || a == 12'hF14);
    endfunction

    function automatic logic [31:0] modelTarget(input logic [31:0] tv, input logic [31:0] cause);
        logic [31:0] base;
        base = tv & 32'hFFFF_FFFC;
        if (tv[0] && cause[31]) return base + cause[30:0] * 4;
        return base;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // One clock edge: the model's next state is derived from the inputs
    // currently on the pins, then both sides advance together.
    task automatic applyStimulus();
        logic [31:0] n_mstatus, n_mie, n_mtvec, n_mscratch, n_mepc, n_mcause, n_mtval;
        logic [63:0] n_cycle, n_instret;
        logic [32:0] oldr;
        logic [31:0] nv;
        logic        wr, cyc_w, ins_w;
        n_mstatus = m_mstatus; n_mie = m_mie; n_mtvec = m_mtvec; n_mscratch = m_mscratch;
        n_mepc = m_mepc; n_mcause = m_mcause; n_mtval = m_mtval;
        n_cycle = m_cycle; n_instret = m_instret;
        if (!rst) begin
            n_mstatus = 32'h88; n_mtvec = 32'h0; n_mie = 0; n_mscratch = 0;
            n_mepc = 0; n_mcause = 0; n_mtval = 0; n_cycle = 0; n_instret = 0;
        end else begin
            oldr = modelRead(waddr);
            wr = csr_w && !modelIllegal(waddr, csr_w);
            if (csr_wsc_mode == 2'b10)      nv = oldr[31:0] | wdata;
            else if (csr_wsc_mode == 2'b11) nv = oldr[31:0] & ~wdata;
            else                            nv = wdata;
            cyc_w = 1'b0;
            ins_w = 1'b0;
            if (wr) begin
                case (waddr)
                    12'h300: n_mstatus = nv;
                    12'h304: n_mie = nv;
                    12'h305: n_mtvec = nv & 32'hFFFF_FFFD;
                    12'h340: n_mscratch = nv;
                    12'h341: n_mepc = nv & 32'hFFFF_FFFC;
                    12'h342: n_mcause = nv;
                    12'h343: n_mtval = nv;
                    12'hB00: begin n_cycle[31:0] = nv; cyc_w = 1'b1; end
                    12'hB80: begin n_cycle[63:32] = nv; cyc_w = 1'b1; end
                    12'hB02: begin n_instret[31:0] = nv; ins_w = 1'b1; end
                    12'hB82: begin n_instret[63:32] = nv; ins_w = 1'b1; end
                    default: ;
                endcase
            end
            if (!cyc_w) n_cycle = m_cycle + 64'd1;
            if (!ins_w && instret_inc) n_instret = m_instret + 64'd1;
            if (trap_valid) begin
                n_mepc = trap_pc & 32'hFFFF_FFFC;
                n_mcause = trap_cause;
                n_mtval = trap_tval;
                n_mstatus = m_mstatus;
                n_mstatus[7] = m_mstatus[3];
                n_mstatus[3] = 1'b0;
                n_mstatus[12:11] = 2'b11;
            end else if (mret) begin
                n_mstatus = m_mstatus;
                n_mstatus[3] = m_mstatus[7];
                n_mstatus[7] = 1'b1;
                n_mstatus[12:11] = 2'b11;
            end
        end
        @(posedge clk);
        m_mstatus = n_mstatus; m_mie = n_mie; m_mtvec = n_mtvec; m_mscratch = n_mscratch;
        m_mepc = n_mepc; m_mcause = n_mcause; m_mtval = n_mtval;
        m_cycle = n_cycle; m_instret = n_instret;
        @(negedge clk);
    endtask

    task automatic idleInputs();
        csr_w = 1'b0; csr_wsc_mode = 2'b01; waddr = 12'h0; wdata = 32'h0;
        instret_inc = 1'b0; trap_valid = 1'b0; mret = 1'b0;
        trap_pc = 32'h0; trap_cause = 32'h0; trap_tval = 32'h0;
    endtask

    task automatic writeCsr(input logic [11:0] a, input logic [31:0] d, input logic [1:0] mode);
        idleInputs();
        csr_w = 1'b1; waddr = a; wdata = d; csr_wsc_mode = mode;
        applyStimulus();
        idleInputs();
    endtask

    task automatic readCheck(input string tag, input logic [11:0] a);
        logic [32:0] e;
        raddr = a;
        #1;
        e = modelRead(a);
        checkOutput(tag, {31'h0, rvalid, rdata}, {31'h0, e});
    endtask

    initial begin
        logic [11:0] addrs [0:17];
        logic [32:0] e;
        addrs = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343, 12'h344,
                  12'hB00, 12'hB02, 12'hB80, 12'hB82, 12'hF14, 12'h7C0, 12'h000, 12'h306, 12'hB01};
        rst = 1'b0;
        raddr = 12'h0;
        idleInputs();
        @(negedge clk);
        applyStimulus();
        applyStimulus();
        rst = 1'b1;

        // Reset values
        raddr = 12'h300; #1; checkOutput("rst_mstatus", 64'(rdata), 64'h88);
        raddr = 12'h305; #1; checkOutput("rst_mtvec", 64'(rdata), 64'h0);
        raddr = 12'hF14; #1; checkOutput("rst_hartid", {31'h0, rvalid, rdata}, {31'h0, 1'b1, 32'h0});
        raddr = 12'h7C0; #1; checkOutput("unimpl_read", {31'h0, rvalid, rdata}, 64'h0);
        raddr = 12'h301; #1; checkOutput("misa", 64'(rdata), 64'h4000_0100);

        // Write / set / clear on mscratch, illegal write to mhartid
        writeCsr(12'h340, 32'hA5A5_0000, 2'b01);
        writeCsr(12'h340, 32'h0000_00FF, 2'b10);
        writeCsr(12'h340, 32'hA500_0000, 2'b11);
        raddr = 12'h340; #1; checkOutput("wsc_mscratch", 64'(rdata), 64'h00A5_00FF);
        csr_w = 1'b1; waddr = 12'hF14; wdata = 32'h1234; #1;
        checkOutput("illegal_hartid", 64'(w_illegal), 64'h1);
        applyStimulus();
        idleInputs();
        raddr = 12'hF14; #1; checkOutput("hartid_kept", 64'(rdata), 64'h0);

        // mcycle carry into mcycleh
        writeCsr(12'hB00, 32'hFFFF_FFFE, 2'b01);
        writeCsr(12'hB80, 32'h0, 2'b01);
        applyStimulus();
        applyStimulus();
        raddr = 12'hB80; #1; checkOutput("mcycleh_carry", 64'(rdata), 64'h1);
        raddr = 12'hB00; #1; checkOutput("mcycle_wrap", 64'(rdata), 64'h0);

        // Vectored trap and mret
        writeCsr(12'h300, 32'h8, 2'b01);
        writeCsr(12'h305, 32'h101, 2'b01);
        trap_valid = 1'b1; trap_pc = 32'h104; trap_cause = 32'h8000_0007; trap_tval = 32'h55; #1;
        checkOutput("trap_target", 64'(trap_target), 64'h11C);
        applyStimulus();
        idleInputs();
        checkOutput("trap_mepc", 64'(mepc), 64'h104);
        checkOutput("trap_mie_mpie", {62'h0, mstatus[7], mstatus[3]}, 64'h2);
        checkOutput("mret_target", 64'(mret_target), 64'h104);
        mret = 1'b1;
        applyStimulus();
        idleInputs();
        checkOutput("mret_mie", 64'(mstatus[3]), 64'h1);

        // Same-cycle trap with CSR writes
        trap_valid = 1'b1; trap_pc = 32'h300; trap_cause = 32'h2;
        csr_w = 1'b1; waddr = 12'h341; wdata = 32'h200;
        applyStimulus();
        idleInputs();
        checkOutput("trap_beats_mepc_wr", 64'(mepc), 64'h300);
        trap_valid = 1'b1; trap_pc = 32'h400; trap_cause = 32'h3;
        csr_w = 1'b1; waddr = 12'h340; wdata = 32'h5555;
        applyStimulus();
        idleInputs();
        raddr = 12'h340; #1; checkOutput("trap_mscratch_wr", 64'(rdata), 64'h5555);

        // Reset in the middle of a counter run
        instret_inc = 1'b1;
        repeat (5) applyStimulus();
        rst = 1'b0;
        applyStimulus();
        raddr = 12'hB00; #1; checkOutput("rst_mcycle", 64'(rdata), 64'h0);
        raddr = 12'hB02; #1; checkOutput("rst_minstret", 64'(rdata), 64'h0);
        rst = 1'b1;
        instret_inc = 1'b0;

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            rst          = ($urandom_range(0, 59) != 0);
            csr_w        = $urandom_range(0, 1) == 1;
            waddr        = addrs[$urandom_range(0, 17)];
            wdata        = $urandom();
            csr_wsc_mode = 2'($urandom_range(0, 3));
            instret_inc  = $urandom_range(0, 1) == 1;
            trap_valid   = ($urandom_range(0, 7) == 0);
            mret         = ($urandom_range(0, 7) == 0);
            trap_pc      = $urandom();
            trap_cause   = $urandom();
            trap_tval    = $urandom();
            if ($urandom_range(0, 9) == 0) m_mtvec = m_mtvec;
            #1;
            checkOutput("rnd_w_illegal", 64'(w_illegal), 64'(modelIllegal(waddr, csr_w)));
            checkOutput("rnd_trap_target", 64'(trap_target), 64'(modelTarget(m_mtvec, trap_cause)));
            applyStimulus();
            raddr = addrs[$urandom_range(0, 17)];
            #1;
            e = modelRead(raddr);
            checkOutput("rnd_read", {31'h0, rvalid, rdata}, {31'h0, e});
            checkOutput("rnd_regs", {mstatus, mepc}, {m_mstatus, m_mepc});
            checkOutput("rnd_mtvec", 64'(mtvec), 64'(m_mtvec));
        end
        rst = 1'b1;
        idleInputs();
        readCheck("final_mcycleh", 12'hB80);
        readCheck("final_minstret", 12'hB02);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
